// File: rtl/edit_mode_controller_if.sv
// Front-panel key inputs and edit-state outputs shared by the edit-mode sequencer and its clients.
interface edit_mode_controller_if;
  logic       ClkSec;
  logic       KeyMode;
  logic       KeySet;
  logic       KeyPlus;
  logic       KeyMinus;
  logic [1:0] screen;
  logic       EditMode;
  logic [2:0] EditPos;
  logic       Blink;

  modport master (
    output ClkSec, KeyMode, KeySet, KeyPlus, KeyMinus,
    input  screen, EditMode, EditPos, Blink
  );
  modport slave (
    input  ClkSec, KeyMode, KeySet, KeyPlus, KeyMinus,
    output screen, EditMode, EditPos, Blink
  );
endinterface

// File: rtl/edit_mode_controller.sv
// Debounces Mode/Set/Plus/Minus and sequences screen / EditMode / EditPos for the counter blocks.
// Define BLINK_EN to build the per-second digit blink strobe; otherwise Blink is tied high.
module edit_mode_controller #(
  parameter logic [19:0] DEB_CYCLES  = 20'd50000,
  parameter logic [7:0]  TIMEOUT_SEC = 8'd10,
  parameter int          NUM_SCREENS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  edit_mode_controller_if.slave   bus
);
  localparam int K_MODE = 0;
  localparam int K_SET  = 1;
  localparam logic [1:0] LAST_SCR = 2'(NUM_SCREENS - 1);

  typedef enum logic {VIEW = 1'b0, EDIT = 1'b1} state_e;

  logic [3:0]       raw;
  logic [3:0][19:0] cnt_q;
  logic [3:0]       acc_q, acc_dly_q;
  logic [3:0]       press;
  logic             any_press;

  state_e     state_q, state_d;
  logic [1:0] screen_q, screen_d;
  logic [2:0] pos_q, pos_d;
  logic [7:0] to_q, to_d;

  assign raw       = {bus.KeyMinus, bus.KeyPlus, bus.KeySet, bus.KeyMode};
  // One-cycle pulse on the cycle after the accepted level falls.
  assign press     = acc_dly_q & ~acc_q;
  assign any_press = |press;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      acc_q     <= '1;
      acc_dly_q <= '1;
    end else begin
      acc_dly_q <= acc_q;
      for (int k = 0; k < 4; k++) begin
        if (raw[k] == acc_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == DEB_CYCLES - 20'd1) begin
          acc_q[k] <= raw[k];
          cnt_q[k] <= '0;
        end else begin
          cnt_q[k] <= cnt_q[k] + 20'd1;
        end
      end
    end
  end

  function automatic logic [2:0] start_pos(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd5;
      2'd1:    return 3'd7;
      2'd2:    return 3'd3;
      default: return 3'd1;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    screen_d = screen_q;
    pos_d    = pos_q;
    to_d     = to_q;
    case (state_q)
      VIEW: begin
        if (press[K_MODE]) begin
          screen_d = (screen_q == LAST_SCR) ? 2'd0 : screen_q + 2'd1;
        end else if (press[K_SET]) begin
          state_d = EDIT;
          pos_d   = start_pos(screen_q);
        end
      end
      EDIT: begin
        if (press[K_MODE]) begin
          state_d = VIEW;
          pos_d   = 3'd0;
        end else if (press[K_SET]) begin
          if (pos_q == 3'd0) state_d = VIEW;
          else               pos_d   = pos_q - 3'd1;
          to_d = 8'd0;
        end else if (any_press) begin
          to_d = 8'd0;
        end else if (bus.ClkSec) begin
          if (to_q >= TIMEOUT_SEC - 8'd1) begin
            state_d = VIEW;
            pos_d   = 3'd0;
          end else begin
            to_d = (to_q == 8'hFF) ? to_q : to_q + 8'd1;
          end
        end
      end
      default: state_d = VIEW;
    endcase
    // Timeout only runs while editing.
    if (state_d == VIEW) to_d = 8'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= VIEW;
      screen_q <= 2'd0;
      pos_q    <= 3'd0;
      to_q     <= 8'd0;
    end else begin
      state_q  <= state_d;
      screen_q <= screen_d;
      pos_q    <= pos_d;
      to_q     <= to_d;
    end
  end

`ifdef BLINK_EN
  logic blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (state_d == VIEW || state_q == VIEW || any_press) blink_d = 1'b1;
    else if (bus.ClkSec)                                 blink_d = ~blink_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) blink_q <= 1'b1;
    else        blink_q <= blink_d;
  end

  assign bus.Blink = blink_q;
`else
  assign bus.Blink = 1'b1;
`endif

  assign bus.screen   = screen_q;
  assign bus.EditMode = (state_q == EDIT);
  assign bus.EditPos  = pos_q;
endmodule
